// File: rtl/clk_mon.sv
// clk_mon: measures clk_in period in CLK_50 cycles and flags lock (stable period) or stall (no edges).
// Optional rising-edge counter output edge_cnt is built only when CLK_MON_EDGECNT_EN is defined.
module clk_mon #(
    parameter int EXP_PERIOD = 200000,
    parameter int TOL        = 16,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 262143
) (
    input  logic        CLK_50,
    input  logic        rst,
    input  logic        clk_in,
    output logic [17:0] period,
    output logic        period_valid,
    output logic        locked,
`ifdef CLK_MON_EDGECNT_EN
    output logic [15:0] edge_cnt,
`endif
    output logic        stall
);
    localparam int          GW        = $clog2(LOCK_CNT + 1);
    localparam int          LO_I      = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
    localparam logic [31:0] LO        = 32'(LO_I);
    localparam logic [31:0] HI        = 32'(EXP_PERIOD + TOL);
    localparam logic [17:0] TMO       = 18'(TIMEOUT);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, STALL} state_t;

    state_t          state_q;
    logic            sync1_q, sync2_q, sync3_q;
    logic [17:0]     cnt_q, cnt_d;
    logic [17:0]     period_q;
    logic [GW-1:0]   good_q;
    logic            valid_q, locked_q, stall_q;
    logic            rise, timeout, in_tol;
    logic [18:0]     sum;
    logic [17:0]     meas;

    assign rise    = sync2_q & ~sync3_q;
    assign sum     = {1'b0, cnt_q} + 19'd1;
    assign meas    = sum[18] ? '1 : sum[17:0];
    assign in_tol  = ({14'd0, meas} >= LO) && ({14'd0, meas} <= HI);
    // A rise in the same cycle wins over timeout
    assign timeout = !rise && (cnt_q >= TMO - 18'd1);

    always_comb begin
        cnt_d = cnt_q;
        if (rise)
            cnt_d = '0;
        else if (cnt_q < TMO)
            cnt_d = cnt_q + 18'd1;
    end

    always_ff @(posedge CLK_50 or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= clk_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge CLK_50 or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            period_q <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            stall_q  <= 1'b0;
            good_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= MEASURE;
                    end else if (timeout) begin
                        state_q <= STALL;
                        stall_q <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_q <= meas;
                        valid_q  <= 1'b1;
                        if (!in_tol) begin
                            good_q <= '0;
                        end else if (good_q == GOOD_LAST) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                            good_q   <= good_q + 1'b1;
                        end else begin
                            good_q <= good_q + 1'b1;
                        end
                    end else if (timeout) begin
                        state_q <= STALL;
                        stall_q <= 1'b1;
                        good_q  <= '0;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        period_q <= meas;
                        valid_q  <= 1'b1;
                        if (!in_tol) begin
                            state_q  <= MEASURE;
                            locked_q <= 1'b0;
                            good_q   <= '0;
                        end
                    end else if (timeout) begin
                        state_q  <= STALL;
                        stall_q  <= 1'b1;
                        locked_q <= 1'b0;
                        good_q   <= '0;
                    end
                end
                STALL: begin
                    // First edge after a stall only restarts measurement
                    if (rise) begin
                        state_q <= MEASURE;
                        stall_q <= 1'b0;
                        good_q  <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign stall        = stall_q;

`ifdef CLK_MON_EDGECNT_EN
    logic [15:0] edge_cnt_q;

    always_ff @(posedge CLK_50 or posedge rst) begin
        if (rst)
            edge_cnt_q <= '0;
        else if (rise)
            edge_cnt_q <= edge_cnt_q + 16'd1;
    end

    assign edge_cnt = edge_cnt_q;
`endif

endmodule

// File: doc/clk_mon.md
CLK_MON -- requirements
Module: clk_mon

Interface
REQ-001 Parameter EXP_PERIOD, default 200000, expected clk_in period in CLK_50 cycles.
REQ-002 Parameter TOL, default 16, allowed deviation (+/-) from EXP_PERIOD in cycles.
REQ-003 Parameter LOCK_CNT, default 4, consecutive in-tolerance periods required to lock.
REQ-004 Parameter TIMEOUT, default 262143, cycles without a clk_in rising edge before stall (max 2^18-1).
REQ-005 CLK_50  input  1  sole clock, all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 clk_in  input  1  divided clock under test, asynchronous to CLK_50.
REQ-008 period  output  18  last measured clk_in period in CLK_50 cycles.
REQ-009 period_valid  output  1  one-cycle pulse when period updates.
REQ-010 locked  output  1  high while clk_in period is stable within tolerance.
REQ-011 stall  output  1  high while clk_in has no rising edge for TIMEOUT cycles.
REQ-012 edge_cnt  output  16  rising edges seen since reset (present only with CLK_MON_EDGECNT_EN).

Function
REQ-013 clk_in SHALL pass a 2-FF synchronizer, then a third register; a rising edge (rise) is sync2=1 and sync3=0.
REQ-014 An 18-bit cycle counter cnt SHALL increment every cycle, saturating at TIMEOUT; on rise, cnt <= 0.
REQ-015 On rise, period <= cnt+1 (saturated at 2^18-1) and period_valid SHALL pulse in the same update cycle, except on the first rise after reset or stall.
REQ-016 Latency: period_valid SHALL assert on the 3rd CLK_50 rising edge after clk_in rises (setup met).
REQ-017 FSM states: IDLE, MEASURE, LOCKED, STALL; reset state IDLE.
REQ-018 IDLE: on first rise -> MEASURE, no period_valid; cnt reaching TIMEOUT -> STALL.
REQ-019 MEASURE: in-tolerance period (EXP_PERIOD-TOL <= p <= EXP_PERIOD+TOL) increments good counter; out-of-tolerance clears it; good reaching LOCK_CNT -> LOCKED.
REQ-020 LOCKED: one out-of-tolerance period -> MEASURE with good cleared; cnt reaching TIMEOUT -> STALL.
REQ-021 MEASURE: cnt reaching TIMEOUT -> STALL.
REQ-022 STALL: on rise -> MEASURE, good cleared, no period_valid (first edge after stall is a new start).
REQ-023 locked SHALL be high iff state is LOCKED; stall high iff state is STALL; both registered.
REQ-024 Rise in the same cycle cnt reaches TIMEOUT: rise takes priority, no stall entry.
REQ-025 period SHALL hold its value between updates, including through STALL.

Reset
REQ-026 rst high SHALL asynchronously force: state IDLE, period 0, period_valid 0, locked 0, stall 0, cnt 0, good 0, synchronizer 0, edge_cnt 0.
REQ-027 Reset mid-measurement SHALL discard partial count; the first rise after release does not produce period_valid.

Configuration
REQ-028 Macro CLK_MON_EDGECNT_EN defined: edge_cnt port present, incremented on every rise, wrapping 0xFFFF->0x0000.
REQ-029 Macro CLK_MON_EDGECNT_EN undefined: edge_cnt port and counter absent; all other behaviour identical.

Verification (EXP_PERIOD=20, TOL=1, LOCK_CNT=4, TIMEOUT=63)
REQ-030 clk_in toggling every 10 cycles -> period=20 on each period_valid; first rise gives no pulse; locked rises with 4th valid period.
REQ-031 Locked, one period of 24 cycles inserted -> locked drops at that period_valid; 4 further periods of 20 -> locked again.
REQ-032 Periods of 19 and 21 alternating -> lock achieved; period of 22 -> not counted as good.
REQ-033 clk_in held low 63 cycles after last rise -> stall=1, locked=0, period unchanged; next rise -> stall=0, no period_valid, relock after 4 more good periods.
REQ-034 rst pulsed mid-period -> all outputs 0 immediately (asynchronous); first post-reset rise gives no period_valid.
REQ-035 With CLK_MON_EDGECNT_EN: 65537 rises -> edge_cnt=1; without macro: build has no edge_cnt port.
